// File: rtl/imem_ctrl.sv
// Instruction memory sequencer: boot-loads the RAM from a streaming loader,
// then arbitrates the single RAM port between core fetch and a debug port.
module imem_ctrl #(
    parameter int DEPTH        = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        skip_boot_i,
    input  logic        ld_valid_i,
    input  logic [31:0] ld_data_i,
    input  logic        ld_last_i,
    output logic        ld_ready_o,
    output logic        core_stall_o,
    output logic        err_o,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_addr_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_data_o,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [31:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] dbg_rdata_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam int CW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LAST_WORD  = CW'(DEPTH - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [31:0]   ADDR_LIMIT = 32'(4 * DEPTH);
    localparam logic [31:0]   WORD_MASK  = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_RUN   = 2'b10,
        ST_ERROR = 2'b11
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_s;
    logic [SW-1:0] starve_r;
    logic [SW-1:0] starve_s;
    logic          fetch_gnt_s;
    logic          dbg_gnt_s;
    logic          fetch_in_range_s;
    logic          dbg_in_range_s;

    assign fetch_in_range_s = (fetch_addr_i < ADDR_LIMIT);
    assign dbg_in_range_s   = (dbg_addr_i < ADDR_LIMIT);
    assign dbg_gnt_o        = dbg_gnt_s;

    // Next-state, arbitration and RAM port drive.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        starve_s    = {SW{1'b0}};
        fetch_gnt_s = 1'b0;
        dbg_gnt_s   = 1'b0;
        mem_addr_o  = 32'h0000_0000;
        mem_we_o    = 1'b0;
        mem_wdata_o = 32'h0000_0000;
        case (state_r)
            ST_BOOT: begin
                if (skip_boot_i) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_valid_i) begin
                    mem_we_o    = 1'b1;
                    mem_addr_o  = 32'({cnt_r, 2'b00});
                    mem_wdata_o = ld_data_i;
                    if (ld_last_i) begin
                        state_s = ST_RUN;
                    end else if (cnt_r == LAST_WORD) begin
                        state_s = ST_ERROR;
                    end else begin
                        cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                // A starved debug request steals the slot; the core retries its fetch.
                if (dbg_req_i && (!fetch_req_i || (starve_r == STARVE_MAX))) begin
                    dbg_gnt_s = 1'b1;
                end else begin
                    fetch_gnt_s = fetch_req_i;
                end
                if (dbg_req_i && !dbg_gnt_s) begin
                    starve_s = starve_r + {{(SW-1){1'b0}}, 1'b1};
                end else begin
                    starve_s = {SW{1'b0}};
                end
                if (fetch_gnt_s) begin
                    mem_addr_o = fetch_addr_i & WORD_MASK;
                end else if (dbg_gnt_s) begin
                    mem_addr_o  = dbg_addr_i & WORD_MASK;
                    mem_we_o    = dbg_we_i && dbg_in_range_s;
                    mem_wdata_o = dbg_wdata_i;
                end else begin
                    mem_addr_o = 32'h0000_0000;
                end
            end
            ST_ERROR: begin
                state_s = ST_ERROR;
            end
            default: begin
                state_s = ST_BOOT;
            end
        endcase
    end

    // Sequencer state, load counter and starvation counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r  <= ST_BOOT;
            cnt_r    <= {CW{1'b0}};
            starve_r <= {SW{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            starve_r <= starve_s;
        end
    end

    // Status outputs registered from the next state so they track the FSM exactly.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            core_stall_o <= 1'b1;
            ld_ready_o   <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            core_stall_o <= (state_s != ST_RUN);
            ld_ready_o   <= (state_s == ST_LOAD);
            err_o        <= (state_s == ST_ERROR);
        end
    end

    // Read-data capture: one cycle after grant; out-of-range reads return zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_valid_o <= 1'b0;
            fetch_data_o  <= 32'h0000_0000;
            dbg_rvalid_o  <= 1'b0;
            dbg_rdata_o   <= 32'h0000_0000;
        end else begin
            fetch_valid_o <= fetch_gnt_s;
            if (fetch_gnt_s) begin
                fetch_data_o <= fetch_in_range_s ? mem_rdata_i : 32'h0000_0000;
            end
            dbg_rvalid_o <= dbg_gnt_s && !dbg_we_i;
            if (dbg_gnt_s && !dbg_we_i) begin
                dbg_rdata_o <= dbg_in_range_s ? mem_rdata_i : 32'h0000_0000;
            end
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: RAM array, a cycle-level reference model
// checked every cycle, and literal expectations for each scenario.
module tb_imem_ctrl;

    localparam int DEPTH = 1024;
    localparam int LIMIT = 4;
    localparam int M_BOOT = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_ERR  = 3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        skip_boot_i;
    logic        ld_valid_i;
    logic [31:0] ld_data_i;
    logic        ld_last_i;
    logic        ld_ready_o;
    logic        core_stall_o;
    logic        err_o;
    logic        fetch_req_i;
    logic [31:0] fetch_addr_i;
    logic        fetch_valid_o;
    logic [31:0] fetch_data_o;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [31:0] dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_gnt_o;
    logic        dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic [31:0] mem_addr_o;
    logic        mem_we_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    imem_ctrl #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .rst_i(rst_i), .skip_boot_i(skip_boot_i),
        .ld_valid_i(ld_valid_i), .ld_data_i(ld_data_i), .ld_last_i(ld_last_i),
        .ld_ready_o(ld_ready_o), .core_stall_o(core_stall_o), .err_o(err_o),
        .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
        .fetch_valid_o(fetch_valid_o), .fetch_data_o(fetch_data_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o),
        .dbg_rdata_o(dbg_rdata_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    // RAM array: combinational read, synchronous write; junk outside range.
    logic [31:0] ram [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    end
    always @(posedge clk) begin
        if (mem_we_o) ram[mem_addr_o[11:2]] <= mem_wdata_o;
    end
    assign mem_rdata_i = (mem_addr_o < 32'(4 * DEPTH)) ? ram[mem_addr_o[11:2]] : 32'hBAD0_BAD0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model state
    logic [31:0] gold [DEPTH];
    int          m_state, m_cnt, m_starve;
    logic        m_fv, m_rv;
    logic [31:0] m_fd, m_rd;
    logic        c_fwin, c_dwin, c_we, c_acc;
    logic [31:0] c_addr, c_wdata;

    initial begin
        for (int i = 0; i < DEPTH; i++) gold[i] = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
    end

    function automatic logic in_range(input logic [31:0] a);
        return a < 32'(4 * DEPTH);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        return in_range(a) ? gold[a[11:2]] : 32'h0;
    endfunction

    // Mid-cycle compare against the model, then advance the model one cycle.
    always @(negedge clk) begin
        if (!rst_i) begin
            m_state = M_BOOT; m_cnt = 0; m_starve = 0;
            m_fv = 1'b0; m_rv = 1'b0; m_fd = 32'h0; m_rd = 32'h0;
            chk("rst_stall", core_stall_o, 32'h1);
            chk("rst_ready", ld_ready_o, 32'h0);
            chk("rst_err", err_o, 32'h0);
            chk("rst_fvalid", fetch_valid_o, 32'h0);
            chk("rst_fdata", fetch_data_o, 32'h0);
            chk("rst_rvalid", dbg_rvalid_o, 32'h0);
            chk("rst_rdata", dbg_rdata_o, 32'h0);
            chk("rst_gnt", dbg_gnt_o, 32'h0);
            chk("rst_we", mem_we_o, 32'h0);
        end else begin
            chk("m_stall", core_stall_o, 32'(m_state != M_RUN));
            chk("m_ready", ld_ready_o, 32'(m_state == M_LOAD));
            chk("m_err", err_o, 32'(m_state == M_ERR));
            chk("m_fvalid", fetch_valid_o, 32'(m_fv));
            if (m_fv) chk("m_fdata", fetch_data_o, m_fd);
            chk("m_rvalid", dbg_rvalid_o, 32'(m_rv));
            if (m_rv) chk("m_rdata", dbg_rdata_o, m_rd);

            c_fwin = 1'b0; c_dwin = 1'b0; c_we = 1'b0; c_acc = 1'b0;
            c_addr = 32'h0; c_wdata = 32'h0;
            if (m_state == M_LOAD && ld_valid_i) begin
                c_acc = 1'b1; c_we = 1'b1; c_addr = 32'(m_cnt * 4); c_wdata = ld_data_i;
            end
            if (m_state == M_RUN) begin
                c_dwin = dbg_req_i && (!fetch_req_i || m_starve >= LIMIT);
                c_fwin = fetch_req_i && !c_dwin;
                if (c_fwin) begin
                    c_acc = 1'b1; c_addr = fetch_addr_i & 32'hFFFF_FFFC;
                end
                if (c_dwin) begin
                    c_acc = 1'b1; c_addr = dbg_addr_i & 32'hFFFF_FFFC;
                    c_we = dbg_we_i && in_range(dbg_addr_i); c_wdata = dbg_wdata_i;
                end
            end
            chk("m_gnt", dbg_gnt_o, 32'(c_dwin));
            chk("m_we", mem_we_o, 32'(c_we));
            if (c_acc) chk("m_addr", mem_addr_o, c_addr);
            if (c_we) chk("m_wdata", mem_wdata_o, c_wdata);

            m_fv = c_fwin;
            if (c_fwin) m_fd = model_read(fetch_addr_i);
            m_rv = c_dwin && !dbg_we_i;
            if (m_rv) m_rd = model_read(dbg_addr_i);
            if (c_we) gold[c_addr[11:2]] = c_wdata;
            m_starve = (m_state == M_RUN && dbg_req_i && !c_dwin) ? m_starve + 1 : 0;
            case (m_state)
                M_BOOT: m_state = skip_boot_i ? M_RUN : M_LOAD;
                M_LOAD: if (ld_valid_i) begin
                    if (ld_last_i) m_state = M_RUN;
                    else if (m_cnt == DEPTH - 1) m_state = M_ERR;
                    else m_cnt = m_cnt + 1;
                end
                default: ;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    logic [31:0] boot_words [3];
    int          gnt_at;

    initial begin
        boot_words = '{32'h0000_0013, 32'h0010_0093, 32'h0000_0067};
        rst_i = 1'b0; skip_boot_i = 1'b0; ld_valid_i = 1'b0; ld_data_i = 32'h0; ld_last_i = 1'b0;
        fetch_req_i = 1'b0; fetch_addr_i = 32'h0; dbg_req_i = 1'b0; dbg_we_i = 1'b0;
        dbg_addr_i = 32'h0; dbg_wdata_i = 32'h0;
        repeat (2) step();

        // Boot-load three words
        rst_i = 1'b1;
        step();
        chk("t1_ready_load", ld_ready_o, 32'h1);
        for (int i = 0; i < 3; i++) begin
            ld_valid_i = 1'b1; ld_data_i = boot_words[i]; ld_last_i = (i == 2);
            step();
        end
        ld_valid_i = 1'b0; ld_last_i = 1'b0;
        chk("t1_stall", core_stall_o, 32'h0);
        chk("t1_ready", ld_ready_o, 32'h0);
        chk("t1_ram0", ram[0], 32'h0000_0013);
        chk("t1_ram1", ram[1], 32'h0010_0093);
        chk("t1_ram2", ram[2], 32'h0000_0067);
        step();

        // Skip boot, fetch word 2
        rst_i = 1'b0; step();
        skip_boot_i = 1'b1; rst_i = 1'b1; step();
        chk("t2_stall", core_stall_o, 32'h0);
        fetch_req_i = 1'b1; fetch_addr_i = 32'h8; step();
        fetch_req_i = 1'b0;
        chk("t2_fvalid", fetch_valid_o, 32'h1);
        chk("t2_fdata", fetch_data_o, 32'h0000_0067);
        step();

        // Overflow the loader
        rst_i = 1'b0; step();
        skip_boot_i = 1'b0; rst_i = 1'b1; step();
        fetch_req_i = 1'b1; fetch_addr_i = 32'h0;
        for (int i = 0; i < DEPTH; i++) begin
            ld_valid_i = 1'b1; ld_data_i = 32'h1000_0000 | 32'(i);
            step();
        end
        ld_valid_i = 1'b0;
        chk("t3_err", err_o, 32'h1);
        chk("t3_stall", core_stall_o, 32'h1);
        repeat (3) step();
        chk("t3_fvalid", fetch_valid_o, 32'h0);
        chk("t3_err_sticky", err_o, 32'h1);
        rst_i = 1'b0; #1;
        chk("t3_err_clr", err_o, 32'h0);
        fetch_req_i = 1'b0;
        step();

        // Debug starvation against continuous fetch
        skip_boot_i = 1'b1; rst_i = 1'b1; step();
        fetch_req_i = 1'b1; fetch_addr_i = 32'h4;
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h20;
        gnt_at = 0;
        for (int n = 1; n <= 10; n++) begin
            #1;
            if (dbg_gnt_o) begin
                gnt_at = n;
                break;
            end
            @(posedge clk); #1;
        end
        chk("t4_gnt_cycle", 32'(gnt_at), 32'd5);
        step();
        dbg_req_i = 1'b0; fetch_req_i = 1'b0; #1;
        chk("t4_fvalid", fetch_valid_o, 32'h0);
        chk("t4_rvalid", dbg_rvalid_o, 32'h1);
        chk("t4_rdata", dbg_rdata_o, 32'h1000_0008);

        // Debug write then fetch; out-of-range write and fetch
        step();
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h10; dbg_wdata_i = 32'hDEAD_BEEF; #1;
        chk("t5_gnt", dbg_gnt_o, 32'h1);
        chk("t5_we", mem_we_o, 32'h1);
        step();
        dbg_req_i = 1'b0; fetch_req_i = 1'b1; fetch_addr_i = 32'h10; step();
        fetch_req_i = 1'b0;
        chk("t5_fvalid", fetch_valid_o, 32'h1);
        chk("t5_fdata", fetch_data_o, 32'hDEAD_BEEF);
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'h1000; dbg_wdata_i = 32'h1234_5678; #1;
        chk("t5_oor_gnt", dbg_gnt_o, 32'h1);
        chk("t5_oor_we", mem_we_o, 32'h0);
        step();
        dbg_req_i = 1'b0; dbg_we_i = 1'b0; fetch_req_i = 1'b1; fetch_addr_i = 32'h1000; step();
        fetch_req_i = 1'b0;
        chk("t5_oor_fvalid", fetch_valid_o, 32'h1);
        chk("t5_oor_fdata", fetch_data_o, 32'h0);
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'h13; step();
        dbg_req_i = 1'b0;
        chk("t5_unal_rvalid", dbg_rvalid_o, 32'h1);
        chk("t5_unal_rdata", dbg_rdata_o, 32'hDEAD_BEEF);
        step();

        // Reset in the middle of a load
        rst_i = 1'b0; step();
        skip_boot_i = 1'b0; rst_i = 1'b1; step();
        for (int i = 0; i < 2; i++) begin
            ld_valid_i = 1'b1; ld_data_i = 32'hCAFE_0000 | 32'(i);
            step();
        end
        ld_valid_i = 1'b0;
        #2; rst_i = 1'b0; #1;
        chk("t6_stall", core_stall_o, 32'h1);
        chk("t6_ready", ld_ready_o, 32'h0);
        chk("t6_err", err_o, 32'h0);
        chk("t6_fvalid", fetch_valid_o, 32'h0);
        chk("t6_rvalid", dbg_rvalid_o, 32'h0);
        step();
        rst_i = 1'b1;
        chk("t6_boot_ready", ld_ready_o, 32'h0);
        step();
        chk("t6_load_ready", ld_ready_o, 32'h1);
        ld_valid_i = 1'b1; ld_data_i = 32'h5555_AAAA; ld_last_i = 1'b1; #1;
        chk("t6_restart_addr", mem_addr_o, 32'h0);
        chk("t6_restart_we", mem_we_o, 32'h1);
        step();
        ld_valid_i = 1'b0; ld_last_i = 1'b0;
        chk("t6_ram0", ram[0], 32'h5555_AAAA);
        chk("t6_ram1_kept", ram[1], 32'hCAFE_0001);
        chk("t6_run", core_stall_o, 32'h0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
